// File: rtl/b_mult_pkg.sv
// Shared types and the Baugh-Wooley row generator for the pipelined array multiplier.
package b_mult_pkg;

  localparam int unsigned MAX_W  = 16;
  localparam int unsigned PSUM_W = 2 * MAX_W;

  typedef enum logic [1:0] {
    OP_UMUL = 2'b00,
    OP_SMUL = 2'b01,
    OP_SMAC = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

  typedef struct packed {
    logic              valid;
    op_t               op;
    logic [MAX_W-1:0]  a;
    logic [MAX_W-1:0]  b;
    logic [PSUM_W-1:0] psum;
  } stage_t;

  // Row i of a w-bit array product. In signed mode the cross terms touching exactly one
  // sign bit are inverted and row 0 carries the 2^w + 2^(2w-1) correction constant.
  function automatic logic [PSUM_W-1:0] bw_row(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input int unsigned      w,
    input int unsigned      i,
    input logic             sgn
  );
    logic [PSUM_W-1:0] row;
    logic [MAX_W-1:0]  a_sh;
    logic [MAX_W-1:0]  b_sh;
    logic              pp;
    row  = '0;
    b_sh = b >> i;
    for (int unsigned j = 0; j < MAX_W; j++) begin
      if (j < w) begin
        a_sh = a >> j;
        pp   = a_sh[0] & b_sh[0];
        if (sgn && ((i == w - 1) != (j == w - 1)))
          pp = ~pp;
        row = row | (PSUM_W'(pp) << (i + j));
      end
    end
    if (sgn && (i == 0))
      row = row | (PSUM_W'(1) << w) | (PSUM_W'(1) << (2 * w - 1));
    return row;
  endfunction

endpackage

// File: rtl/b_mult_row_stage.sv
// One pipeline stage: adds ROWS partial-product rows starting at BASE, registers payload on adv.
module b_mult_row_stage
  import b_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 2,
  parameter int unsigned BASE  = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   adv,
  input  stage_t in_p,
  output stage_t out_p
);

  logic [PSUM_W-1:0] sum;
  logic              sgn;

  always_comb begin
    sgn = (in_p.op != OP_UMUL);
    sum = in_p.psum;
    for (int unsigned r = 0; r < ROWS; r++)
      sum = sum + bw_row(in_p.a, in_p.b, WIDTH, BASE + r, sgn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p <= '0;
    end else if (adv) begin
      out_p      <= in_p;
      out_p.psum <= sum;
    end
  end

endmodule

// File: rtl/b_array_mult_pipe.sv
// Pipelined array multiplier with UMUL/SMUL/SMAC/CLR ops and valid/ready on both sides.
module b_array_mult_pipe
  import b_mult_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned STAGES = 4,
  parameter  int unsigned GUARD  = 4,
  localparam int unsigned ACC_W  = 2 * WIDTH + GUARD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_result,
  output logic [1:0]       out_op
);

  localparam int unsigned ROWS = WIDTH / STAGES;

  if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > MAX_W) begin : g_bad_width
    $error("b_array_mult_pipe: WIDTH must be even, >= 4 and <= %0d", MAX_W);
  end
  if ((WIDTH % STAGES) != 0) begin : g_bad_stages
    $error("b_array_mult_pipe: WIDTH must be a multiple of STAGES");
  end

  logic               adv;
  stage_t             head;
  stage_t             tail [STAGES];
  stage_t             last;
  logic [2*WIDTH-1:0] prod;
  logic [ACC_W-1:0]   prod_z;
  logic [ACC_W-1:0]   prod_s;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   result;
  logic               unused_tail;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    head       = '0;
    head.valid = in_valid;
    head.op    = op_t'(in_op);
    head.a     = MAX_W'(in_a);
    head.b     = MAX_W'(in_b);
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      b_mult_row_stage #(.WIDTH(WIDTH), .ROWS(ROWS), .BASE(0)) u_stage (
        .clk(clk), .rst_n(rst_n), .adv(adv), .in_p(head), .out_p(tail[0])
      );
    end else begin : g_next
      b_mult_row_stage #(.WIDTH(WIDTH), .ROWS(ROWS), .BASE(s * ROWS)) u_stage (
        .clk(clk), .rst_n(rst_n), .adv(adv), .in_p(tail[s-1]), .out_p(tail[s])
      );
    end
  end

  assign last        = tail[STAGES-1];
  assign unused_tail = ^{last.a, last.b, last.psum};

  // Accumulation lives in the output stage so back-to-back SMACs see the fresh acc.
  always_comb begin
    prod    = last.psum[2*WIDTH-1:0];
    prod_z  = ACC_W'(prod);
    prod_s  = ACC_W'($signed(prod));
    acc_sum = acc + prod_s;
    unique case (last.op)
      OP_UMUL: result = prod_z;
      OP_SMUL: result = prod_s;
      OP_SMAC: result = acc_sum;
      OP_CLR:  result = '0;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_op     <= 2'b00;
      acc        <= '0;
    end else if (adv) begin
      out_valid <= last.valid;
      if (last.valid) begin
        out_result <= result;
        out_op     <= last.op;
        if (last.op == OP_SMAC || last.op == OP_CLR)
          acc <= result;
      end
    end
  end

endmodule

// File: tb/tb_b_array_mult_pipe.sv
// Directed bench for b_array_mult_pipe (WIDTH=8, STAGES=4, GUARD=4, ACC_W=20).
module tb_b_array_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_result;
  logic [1:0]  out_op;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_cyc;
  int c1;

  logic [19:0] res_q [$];
  logic [1:0]  op_q  [$];
  int          cyc_q [$];

  b_array_mult_pipe #(.WIDTH(8), .STAGES(4), .GUARD(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      res_q.push_back(out_result);
      op_q.push_back(out_op);
      cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int budget = 50;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    #1;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    chk("send_accept_timeout", budget > 0, budget, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int budget = 300;
    while (res_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    chk("result_wait_timeout", res_q.size() >= n, res_q.size(), n);
  endtask

  task automatic check_next(input string tag, input logic [19:0] er, input logic [1:0] eo);
    logic [19:0] r = 'x;
    logic [1:0]  o = 'x;
    last_cyc = -1;
    if (res_q.size() > 0) begin
      r        = res_q.pop_front();
      o        = op_q.pop_front();
      last_cyc = cyc_q.pop_front();
    end
    chk(tag, r === er, r, er);
    chk({tag, "_op"}, o === eo, o, eo);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 2'b00;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready === 1'b1, in_ready, 1);
    chk("rst_out_valid", out_valid === 1'b0, out_valid, 0);
    chk("rst_out_result", out_result === 20'h00000, out_result, 0);
    chk("rst_out_op", out_op === 2'b00, out_op, 0);
    tick();
    rst_n = 1'b1;

    send(2'b00, 8'hFF, 8'hFF);
    chk("lat_edge0", out_valid === 1'b0, out_valid, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("lat_early", out_valid === 1'b0, out_valid, 0);
    end
    tick();
    chk("lat_edge4", out_valid === 1'b1, out_valid, 1);
    chk("umul_255sq", out_result === 20'h0FE01, out_result, 32'h0FE01);
    chk("umul_op", out_op === 2'b00, out_op, 0);
    tick();
    res_q.delete(); op_q.delete(); cyc_q.delete();

    send(2'b01, 8'h80, 8'h80);
    send(2'b01, 8'hFF, 8'h7F);
    wait_results(2);
    check_next("smul_m128sq", 20'h04000, 2'b01);
    c1 = last_cyc;
    check_next("smul_m1x127", 20'hFFF81, 2'b01);
    chk("smul_consecutive", (last_cyc - c1) == 1, last_cyc - c1, 1);

    send(2'b11, 8'h55, 8'hAA);
    send(2'b10, 8'd3, 8'd4);
    send(2'b10, 8'hFB, 8'd6);
    send(2'b10, 8'd100, 8'd100);
    wait_results(4);
    check_next("mac_clr", 20'h00000, 2'b11);
    check_next("mac_3x4", 20'd12, 2'b10);
    check_next("mac_m5x6", 20'hFFFEE, 2'b10);
    check_next("mac_100sq", 20'd9982, 2'b10);
    chk("mac_acc_final", dut.acc === 20'd9982, dut.acc, 9982);

    for (int i = 1; i <= 5; i++)
      send(2'b00, 8'(i), 8'd2);
    in_valid  = 1'b1;
    in_op     = 2'b00;
    in_a      = 8'd6;
    in_b      = 8'd2;
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready", in_ready === 1'b0, in_ready, 0);
    chk("stall_out_valid", out_valid === 1'b1, out_valid, 1);
    chk("stall_result", out_result === 20'd2, out_result, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_valid", out_valid === 1'b1, out_valid, 1);
      chk("stall_hold_result", out_result === 20'd2, out_result, 2);
      chk("stall_hold_ready", in_ready === 1'b0, in_ready, 0);
    end
    out_ready = 1'b1;
    send(2'b00, 8'd6, 8'd2);
    wait_results(6);
    for (int i = 1; i <= 6; i++)
      check_next("stall_seq", 20'(2 * i), 2'b00);
    repeat (10) tick();
    chk("stall_no_dup", res_q.size() == 0, res_q.size(), 0);

    send(2'b11, 8'h00, 8'h00);
    for (int i = 0; i < 32; i++)
      send(2'b10, 8'h80, 8'h80);
    wait_results(33);
    check_next("wrap_clr", 20'h00000, 2'b11);
    for (int i = 1; i <= 32; i++)
      check_next("wrap_seq", 20'(i * 16384), 2'b10);

    send(2'b10, 8'd1, 8'd1);
    send(2'b10, 8'd2, 8'd2);
    send(2'b10, 8'd3, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid === 1'b0, out_valid, 0);
    chk("midrst_acc", dut.acc === 20'h00000, dut.acc, 0);
    chk("midrst_in_ready", in_ready === 1'b1, in_ready, 1);
    chk("midrst_out_result", out_result === 20'h00000, out_result, 0);
    #2;
    rst_n = 1'b1;
    send(2'b10, 8'd2, 8'd3);
    wait_results(1);
    check_next("post_rst_smac", 20'd6, 2'b10);
    repeat (10) tick();
    chk("post_rst_no_stale", res_q.size() == 0, res_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
